// File: rtl/bp_be_pkg.sv
// rtl/bp_be_pkg.sv - shared types and constants for the stride detector
package bp_be_pkg;

    typedef enum logic [0:0] {e_bp_default_cfg} bp_params_e;

    localparam int bp_be_vaddr_width_gp  = 39;
    localparam int bp_be_stride_width_gp = 16;
    localparam int bp_be_conf_width_gp   = 3;

    typedef enum logic [1:0] {e_sd_idle, e_sd_discover, e_sd_confirmed} bp_be_stride_state_e;

    typedef struct packed {
        logic                                    valid;
        logic [bp_be_vaddr_width_gp-1:0]         pc;
        logic [bp_be_vaddr_width_gp-1:0]         last_addr;
        logic signed [bp_be_stride_width_gp-1:0] stride;
        logic [bp_be_conf_width_gp-1:0]          conf;
    } bp_be_stride_entry_s;

    function automatic int vaddr_width(bp_params_e cfg);
        case (cfg)
            e_bp_default_cfg: return bp_be_vaddr_width_gp;
            default:          return bp_be_vaddr_width_gp;
        endcase
    endfunction

endpackage

// File: rtl/bp_be_stride_table.sv
// rtl/bp_be_stride_table.sv - fully-associative PC-indexed stride table with round-robin allocation
module bp_be_stride_table
    import bp_be_pkg::*;
#(
    parameter int  entries_p    = 4,
    localparam int idx_width_lp = (entries_p > 1) ? $clog2(entries_p) : 1
) (
    input  logic                                    clk_i,
    input  logic                                    reset_n_i,
    input  logic                                    ld_v_i,
    input  logic [bp_be_vaddr_width_gp-1:0]         ld_pc_i,
    input  logic [bp_be_vaddr_width_gp-1:0]         ld_addr_i,
    output logic                                    hit_o,
    output logic [idx_width_lp-1:0]                 idx_o,
    output logic [bp_be_conf_width_gp-1:0]          new_conf_o,
    output logic                                    conf_reset_o,
    output logic signed [bp_be_stride_width_gp-1:0] stride_o
);

    localparam int va_lp = bp_be_vaddr_width_gp;
    localparam int sw_lp = bp_be_stride_width_gp;

    bp_be_stride_entry_s            tbl_r [entries_p];
    logic [idx_width_lp-1:0]        rr_r;
    bp_be_stride_entry_s            cur;
    logic [va_lp-1:0]               delta;
    logic                           in_range;
    logic                           match;

    // On a miss idx_o points at the allocation victim so the caller can detect evictions.
    always_comb begin
        hit_o = 1'b0;
        idx_o = rr_r;
        for (int i = 0; i < entries_p; i++) begin
            if (tbl_r[i].valid && (tbl_r[i].pc == ld_pc_i)) begin
                hit_o = 1'b1;
                idx_o = idx_width_lp'(i);
            end
        end
    end

    assign cur      = tbl_r[idx_o];
    assign delta    = ld_addr_i - cur.last_addr;
    assign in_range = (delta[va_lp-1:sw_lp-1] == {(va_lp-sw_lp+1){delta[sw_lp-1]}});
    assign match    = hit_o && in_range && (delta[sw_lp-1:0] == cur.stride) && (delta != '0);

    assign new_conf_o   = match ? ((cur.conf == '1) ? cur.conf : cur.conf + 1'b1) : '0;
    assign conf_reset_o = hit_o && !match;
    assign stride_o     = delta[sw_lp-1:0];

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            rr_r <= '0;
            for (int i = 0; i < entries_p; i++) begin
                tbl_r[i] <= '0;
            end
        end else if (ld_v_i) begin
            if (hit_o) begin
                tbl_r[idx_o].last_addr <= ld_addr_i;
                tbl_r[idx_o].conf      <= new_conf_o;
                if (!match) begin
                    tbl_r[idx_o].stride <= stride_o;
                end
            end else begin
                tbl_r[rr_r] <= '{valid: 1'b1, pc: ld_pc_i, last_addr: ld_addr_i, stride: '0, conf: '0};
                rr_r        <= (rr_r == idx_width_lp'(entries_p - 1)) ? '0 : rr_r + 1'b1;
            end
        end
    end

endmodule

// File: rtl/bp_be_stride_detector.sv
// rtl/bp_be_stride_detector.sv - selects one striding load per episode for downstream loop inference
module bp_be_stride_detector
    import bp_be_pkg::*;
#(
    parameter bp_params_e bp_params_p    = e_bp_default_cfg,
    parameter int         entries_p      = 4,
    parameter int         stride_width_p = bp_be_stride_width_gp,
    parameter int         start_conf_p   = 2,
    parameter int         confirm_conf_p = 4,
    parameter int         timeout_p      = 1024,
    localparam int        vaddr_width_p  = vaddr_width(bp_params_p),
    localparam int        idx_width_lp   = (entries_p > 1) ? $clog2(entries_p) : 1,
    localparam int        tcnt_width_lp  = (timeout_p > 1) ? $clog2(timeout_p) : 1
) (
    input  logic                             clk_i,
    input  logic                             reset_n_i,
    input  logic                             ld_v_i,
    input  logic [vaddr_width_p-1:0]         ld_pc_i,
    input  logic [vaddr_width_p-1:0]         ld_addr_i,
    output logic                             start_discovery_o,
    output logic                             confirm_discovery_o,
    output logic [vaddr_width_p-1:0]         striding_pc_o,
    output logic signed [stride_width_p-1:0] stride_o,
    input  logic                             loop_done_i,
    output logic                             busy_o
);

    logic                             hit;
    logic [idx_width_lp-1:0]          idx;
    logic [bp_be_conf_width_gp-1:0]   new_conf;
    logic                             conf_reset;
    logic signed [stride_width_p-1:0] upd_stride;

    bp_be_stride_table #(.entries_p(entries_p)) table_inst (
        .clk_i        (clk_i),
        .reset_n_i    (reset_n_i),
        .ld_v_i       (ld_v_i),
        .ld_pc_i      (ld_pc_i),
        .ld_addr_i    (ld_addr_i),
        .hit_o        (hit),
        .idx_o        (idx),
        .new_conf_o   (new_conf),
        .conf_reset_o (conf_reset),
        .stride_o     (upd_stride)
    );

    bp_be_stride_state_e              state_r, state_n;
    logic [idx_width_lp-1:0]          idx_r, idx_n;
    logic [vaddr_width_p-1:0]         pc_r, pc_n;
    logic signed [stride_width_p-1:0] stride_r, stride_n;
    logic [tcnt_width_lp-1:0]         tcnt_r, tcnt_n;
    logic                             start_r, start_n;
    logic                             confirm_r, confirm_n;

    logic upd, tracked, evicted;
    assign upd     = ld_v_i && hit;
    assign tracked = upd && (idx == idx_r);
    assign evicted = ld_v_i && !hit && (idx == idx_r);

    always_comb begin
        state_n   = state_r;
        idx_n     = idx_r;
        pc_n      = pc_r;
        stride_n  = stride_r;
        tcnt_n    = tcnt_r;
        start_n   = 1'b0;
        confirm_n = 1'b0;
        unique case (state_r)
            // Only an exact step onto start_conf_p arms, so saturated entries never re-fire.
            e_sd_idle: begin
                if (upd && (new_conf == bp_be_conf_width_gp'(start_conf_p))) begin
                    state_n  = e_sd_discover;
                    start_n  = 1'b1;
                    idx_n    = idx;
                    pc_n     = ld_pc_i;
                    stride_n = upd_stride;
                    tcnt_n   = '0;
                end
            end
            e_sd_discover: begin
                if (tracked && (new_conf == bp_be_conf_width_gp'(confirm_conf_p))) begin
                    state_n   = e_sd_confirmed;
                    confirm_n = 1'b1;
                end else if ((tracked && conf_reset) || evicted) begin
                    state_n = e_sd_idle;
                end else if (tcnt_r == tcnt_width_lp'(timeout_p - 1)) begin
                    state_n = e_sd_idle;
                end else begin
                    tcnt_n = tcnt_r + 1'b1;
                end
            end
            e_sd_confirmed: begin
                if (loop_done_i) begin
                    state_n = e_sd_idle;
                end
            end
            default: state_n = e_sd_idle;
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_r   <= e_sd_idle;
            idx_r     <= '0;
            pc_r      <= '0;
            stride_r  <= '0;
            tcnt_r    <= '0;
            start_r   <= 1'b0;
            confirm_r <= 1'b0;
        end else begin
            state_r   <= state_n;
            idx_r     <= idx_n;
            pc_r      <= pc_n;
            stride_r  <= stride_n;
            tcnt_r    <= tcnt_n;
            start_r   <= start_n;
            confirm_r <= confirm_n;
        end
    end

    assign start_discovery_o   = start_r;
    assign confirm_discovery_o = confirm_r;
    assign striding_pc_o       = pc_r;
    assign stride_o            = stride_r;
    assign busy_o              = (state_r != e_sd_idle);

endmodule

// File: tb/tb_bp_be_stride_detector.sv
// tb/tb_bp_be_stride_detector.sv - directed plus randomized bench with a behavioural stride model
module tb_bp_be_stride_detector;

    localparam int     VA   = 39;
    localparam longint MASK = (64'sd1 <<< VA) - 1;

    logic              clk = 1'b0;
    logic              reset_n, ld_v, loop_done;
    logic [VA-1:0]     ld_pc, ld_addr;
    logic              start_o, confirm_o, busy;
    logic [VA-1:0]     spc;
    logic signed [15:0] sstride;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    bp_be_stride_detector dut (
        .clk_i               (clk),
        .reset_n_i           (reset_n),
        .ld_v_i              (ld_v),
        .ld_pc_i             (ld_pc),
        .ld_addr_i           (ld_addr),
        .start_discovery_o   (start_o),
        .confirm_discovery_o (confirm_o),
        .striding_pc_o       (spc),
        .stride_o            (sstride),
        .loop_done_i         (loop_done),
        .busy_o              (busy)
    );

    // Model: table as plain arrays of signed integers, episode as a mode number.
    bit     m_valid [4];
    longint m_pc [4], m_last [4], m_stride [4];
    int     m_conf [4];
    int     m_rr, m_mode, m_tidx, m_tcnt;
    longint m_tpc, m_tstride;
    bit     m_start, m_confirm;

    function automatic void model_reset();
        for (int i = 0; i < 4; i++) begin
            m_valid[i] = 0; m_pc[i] = 0; m_last[i] = 0; m_stride[i] = 0; m_conf[i] = 0;
        end
        m_rr = 0; m_mode = 0; m_tidx = -1; m_tcnt = 0;
        m_tpc = 0; m_tstride = 0; m_start = 0; m_confirm = 0;
    endfunction

    function automatic void model_step(bit v, longint pc, longint addr, bit done);
        int     idx = -1;
        longint d = 0, sd = 0, t = 0;
        bit     match = 0;
        int     nc = 0;
        m_start = 0;
        m_confirm = 0;
        if (v) for (int i = 0; i < 4; i++) if (m_valid[i] && m_pc[i] == pc) idx = i;
        if (idx >= 0) begin
            d  = (addr - m_last[idx]) & MASK;
            sd = (d >= (64'sd1 <<< (VA - 1))) ? d - (64'sd1 <<< VA) : d;
            match = (sd >= -32768) && (sd <= 32767) && (sd == m_stride[idx]) && (sd != 0);
            nc = match ? ((m_conf[idx] == 7) ? 7 : m_conf[idx] + 1) : 0;
        end
        case (m_mode)
            0: if (idx >= 0 && match && nc == 2) begin
                m_mode = 1; m_start = 1; m_tidx = idx; m_tpc = pc; m_tstride = sd; m_tcnt = 0;
            end
            1: begin
                if (idx == m_tidx && match && nc == 4) begin
                    m_mode = 2; m_confirm = 1;
                end else if (idx == m_tidx && !match) m_mode = 0;
                else if (v && idx < 0 && m_rr == m_tidx) m_mode = 0;
                else if (m_tcnt == 1023) m_mode = 0;
                else m_tcnt++;
            end
            default: if (done) m_mode = 0;
        endcase
        if (v) begin
            if (idx >= 0) begin
                m_last[idx] = addr;
                m_conf[idx] = nc;
                if (!match) begin
                    t = d & 64'hFFFF;
                    m_stride[idx] = (t >= 32768) ? t - 65536 : t;
                end
            end else begin
                m_valid[m_rr] = 1; m_pc[m_rr] = pc; m_last[m_rr] = addr;
                m_stride[m_rr] = 0; m_conf[m_rr] = 0;
                m_rr = (m_rr + 1) % 4;
            end
        end
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs();
        chk("start", {63'd0, start_o}, {63'd0, m_start});
        chk("confirm", {63'd0, confirm_o}, {63'd0, m_confirm});
        chk("busy", {63'd0, busy}, (m_mode != 0) ? 64'd1 : 64'd0);
        chk("striding_pc", {25'd0, spc}, m_tpc);
        chk("stride", {48'd0, $unsigned(sstride)}, m_tstride & 64'hFFFF);
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_start"}, {63'd0, start_o}, 64'd0);
        chk({tag, "_confirm"}, {63'd0, confirm_o}, 64'd0);
        chk({tag, "_busy"}, {63'd0, busy}, 64'd0);
        chk({tag, "_pc"}, {25'd0, spc}, 64'd0);
        chk({tag, "_stride"}, {48'd0, $unsigned(sstride)}, 64'd0);
    endtask

    task automatic step(input bit v, input longint pc, input longint addr, input bit done);
        ld_v = v; ld_pc = pc[VA-1:0]; ld_addr = addr[VA-1:0]; loop_done = done;
        model_step(v, pc & MASK, addr & MASK, done);
        @(posedge clk); #1;
        check_outputs();
    endtask

    task automatic do_reset();
        reset_n = 1'b0; ld_v = 0; loop_done = 0; ld_pc = '0; ld_addr = '0;
        #2;
        check_zero("reset");
        @(posedge clk); #1;
        reset_n = 1'b1;
        model_reset();
    endtask

    longint picks [8] = '{8, -8, 64, 32767, -32768, 32768, 0, 12345};
    longint gpc [6], glast [6], gstr [6];

    initial begin
        model_reset();
        do_reset();

        // Training: start after the 4th strided load, confirm after the 6th.
        for (int i = 0; i < 6; i++) begin
            step(1, 'h100, 'h1000 + 8 * i, 0);
            if (i == 3) begin
                chk("t1_start", {63'd0, start_o}, 64'd1);
                chk("t1_pc", {25'd0, spc}, 64'h100);
                chk("t1_stride", {48'd0, $unsigned(sstride)}, 64'd8);
            end
        end
        chk("t2_confirm", {63'd0, confirm_o}, 64'd1);
        chk("t2_busy", {63'd0, busy}, 64'd1);
        step(0, 0, 0, 1);
        chk("t2_done_busy", {63'd0, busy}, 64'd0);

        // Stride break in DISCOVER, then re-train.
        for (int i = 0; i < 4; i++) step(1, 'h100, 'h2000 + 8 * i, 0);
        chk("t3_start", {63'd0, start_o}, 64'd1);
        step(1, 'h100, 'h3000, 0);
        chk("t3_break_busy", {63'd0, busy}, 64'd0);
        for (int i = 1; i < 4; i++) step(1, 'h100, 'h3000 + 8 * i, 0);
        chk("t3_restart", {63'd0, start_o}, 64'd1);

        // Timeout, then no re-fire from an already-trained entry.
        for (int i = 0; i < 1023; i++) step(0, 0, 0, 0);
        chk("t4_before_timeout", {63'd0, busy}, 64'd1);
        step(0, 0, 0, 0);
        chk("t4_timeout", {63'd0, busy}, 64'd0);
        step(1, 'h100, 'h3020, 0);
        chk("t4_no_refire", {63'd0, start_o}, 64'd0);

        // Eviction of the tracked entry.
        do_reset();
        for (int i = 0; i < 4; i++) step(1, 'h100, 'h1000 + 8 * i, 0);
        step(1, 'h200, 'h5000, 0);
        step(1, 'h300, 'h6000, 0);
        step(1, 'h400, 'h7000, 0);
        chk("t5_still_busy", {63'd0, busy}, 64'd1);
        step(1, 'h500, 'h8000, 0);
        chk("t5_evict_busy", {63'd0, busy}, 64'd0);

        // Asynchronous reset while CONFIRMED.
        do_reset();
        for (int i = 0; i < 6; i++) step(1, 'h100, 'h1000 + 8 * i, 0);
        chk("t6_confirmed", {63'd0, busy}, 64'd1);
        #2;
        reset_n = 1'b0;
        #1;
        check_zero("t6_async");
        model_reset();
        @(posedge clk); #1;
        reset_n = 1'b1;
        for (int i = 0; i < 3; i++) step(0, 0, 0, 0);

        // Randomized traffic: biased to four hot PCs so episodes actually form.
        for (int k = 0; k < 6; k++) begin
            gpc[k]   = 'h1000 + 'h40 * k;
            glast[k] = longint'({$urandom(), $urandom()}) & MASK;
            gstr[k]  = picks[$urandom_range(0, 7)];
        end
        for (int n = 0; n < 3000; n++) begin
            int  k;
            bit  v;
            k = ($urandom_range(0, 7) == 0) ? $urandom_range(4, 5) : $urandom_range(0, 3);
            v = ($urandom_range(0, 3) != 0);
            if (v) begin
                if ($urandom_range(0, 15) == 0) gstr[k] = picks[$urandom_range(0, 7)];
                if ($urandom_range(0, 31) == 0) glast[k] = longint'({$urandom(), $urandom()});
                else glast[k] = glast[k] + gstr[k];
                glast[k] = glast[k] & MASK;
            end
            step(v, gpc[k], glast[k], $urandom_range(0, 15) == 0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
